// File: rtl/irq_capture_arbiter.sv
// Captures one-cycle interrupt strobes from four sources and presents one pending
// event at a time as a strictly one-hot vector plus its payload, under valid/ack.
module irq_capture_arbiter #(
    parameter int RR_EN = 0,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [3:0]   req_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    input  logic         ack_i,
    input  logic         ovf_clr_i,
    output logic         valid_o,
    output logic [3:0]   interrupt_o,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic [W-1:0] c_o,
    output logic [W-1:0] d_o,
    output logic [3:0]   pending_o,
    output logic [3:0]   ovf_o
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          pending_q, ovf_q, irq_q, irq_d, ack_vec;
    logic [3:0][W-1:0]   lat_q, lane_q, lane_d, pay_in;
    logic                valid_q, valid_d;
    logic [1:0]          win_q, win_d, ptr_q, ptr_d, sel_idx, cand;
    logic                sel_found;

    assign pay_in  = {a_i, b_i, c_i, d_i};
    assign ack_vec = (state_q == PRESENT && ack_i) ? (4'b0001 << win_q) : 4'b0000;

    // A strobe on the edge that acks the same source re-arms it instead of overflowing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            ovf_q     <= '0;
            lat_q     <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (req_i[k]) begin
                    if (!pending_q[k] || ack_vec[k]) begin
                        pending_q[k] <= 1'b1;
                        lat_q[k]     <= pay_in[k];
                    end
                end else if (ack_vec[k]) begin
                    pending_q[k] <= 1'b0;
                end
            end
            ovf_q <= (ovf_clr_i ? 4'b0000 : ovf_q) | (req_i & pending_q & ~ack_vec);
        end
    end

    // The pointer holds the first bit to search; fixed priority always starts at 3.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = (RR_EN != 0) ? ptr_q - 2'(i) : 2'(3 - i);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        irq_d   = irq_q;
        lane_d  = lane_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d         = PRESENT;
                    valid_d         = 1'b1;
                    irq_d           = 4'b0001 << sel_idx;
                    lane_d          = '0;
                    lane_d[sel_idx] = lat_q[sel_idx];
                    win_d           = sel_idx;
                    ptr_d           = sel_idx - 2'd1;
                end
            end
            PRESENT: begin
                if (ack_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    irq_d   = 4'b0000;
                    lane_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            irq_q   <= 4'b0000;
            lane_q  <= '0;
            win_q   <= 2'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            irq_q   <= irq_d;
            lane_q  <= lane_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_o     = valid_q;
    assign interrupt_o = irq_q;
    assign a_o         = lane_q[3];
    assign b_o         = lane_q[2];
    assign c_o         = lane_q[1];
    assign d_o         = lane_q[0];
    assign pending_o   = pending_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_irq_capture_arbiter.sv
// Directed bench: one fixed-priority instance and one round-robin instance
// share clock and reset; expected values are hand-computed constants.
module tb_irq_capture_arbiter;

    logic clk, rst_n;

    logic [3:0]      req_f, irq_f, pend_f, ovf_f;
    logic [3:0][7:0] pin_f, pout_f;
    logic            ack_f, clr_f, valid_f;

    logic [3:0]      req_r, irq_r, pend_r, ovf_r;
    logic [3:0][7:0] pin_r, pout_r;
    logic            ack_r, clr_r, valid_r;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  pays [4];
    logic [3:0]  exp_irq;
    logic [31:0] exp_lane;

    irq_capture_arbiter #(.RR_EN(0), .W(8)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_f),
        .a_i(pin_f[3]), .b_i(pin_f[2]), .c_i(pin_f[1]), .d_i(pin_f[0]),
        .ack_i(ack_f), .ovf_clr_i(clr_f), .valid_o(valid_f), .interrupt_o(irq_f),
        .a_o(pout_f[3]), .b_o(pout_f[2]), .c_o(pout_f[1]), .d_o(pout_f[0]),
        .pending_o(pend_f), .ovf_o(ovf_f)
    );

    irq_capture_arbiter #(.RR_EN(1), .W(8)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_r),
        .a_i(pin_r[3]), .b_i(pin_r[2]), .c_i(pin_r[1]), .d_i(pin_r[0]),
        .ack_i(ack_r), .ovf_clr_i(clr_r), .valid_o(valid_r), .interrupt_o(irq_r),
        .a_o(pout_r[3]), .b_o(pout_r[2]), .c_o(pout_r[1]), .d_o(pout_r[0]),
        .pending_o(pend_r), .ovf_o(ovf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_f = '0; pin_f = '0; ack_f = 1'b0; clr_f = 1'b0;
        req_r = '0; pin_r = '0; ack_r = 1'b0; clr_r = 1'b0;
        applyStimulus(3);
        checkOutput("rst_valid", 32'(valid_f), 32'h0);
        checkOutput("rst_irq", 32'(irq_f), 32'h0);
        checkOutput("rst_lanes", pout_f, 32'h0);
        checkOutput("rst_pending", 32'(pend_f), 32'h0);
        checkOutput("rst_ovf", 32'(ovf_f), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1);

        $display("[TB] single strobe on source c");
        req_f = 4'b0010; pin_f[1] = 8'h5A;
        applyStimulus(1);
        req_f = '0; pin_f = '0;
        checkOutput("single_pend", 32'(pend_f), 32'h2);
        checkOutput("single_valid_lat1", 32'(valid_f), 32'h0);
        applyStimulus(1);
        checkOutput("single_valid", 32'(valid_f), 32'h1);
        checkOutput("single_irq", 32'(irq_f), 32'h2);
        checkOutput("single_lanes", pout_f, 32'h00005A00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("hold_irq", 32'(irq_f), 32'h2);
            checkOutput("hold_lanes", pout_f, 32'h00005A00);
        end
        ack_f = 1'b1;
        applyStimulus(1);
        ack_f = 1'b0;
        checkOutput("ack_valid", 32'(valid_f), 32'h0);
        checkOutput("ack_irq", 32'(irq_f), 32'h0);
        checkOutput("ack_lanes", pout_f, 32'h0);
        checkOutput("ack_pending", 32'(pend_f), 32'h0);

        $display("[TB] fixed priority with all four sources");
        pays[3] = 8'hA0; pays[2] = 8'hB0; pays[1] = 8'hC0; pays[0] = 8'hD0;
        req_f = 4'b1111; pin_f = {8'hA0, 8'hB0, 8'hC0, 8'hD0};
        applyStimulus(1);
        req_f = '0; pin_f = '0;
        applyStimulus(1);
        for (int g = 3; g >= 0; g--) begin
            exp_irq  = 4'b0001 << g;
            exp_lane = 32'(pays[g]) << (8 * g);
            checkOutput("fp_valid", 32'(valid_f), 32'h1);
            checkOutput("fp_irq", 32'(irq_f), 32'(exp_irq));
            checkOutput("fp_lanes", pout_f, exp_lane);
            ack_f = 1'b1;
            applyStimulus(1);
            ack_f = 1'b0;
            checkOutput("fp_gap_valid", 32'(valid_f), 32'h0);
            applyStimulus(1);
        end
        checkOutput("fp_drained", 32'(valid_f), 32'h0);
        checkOutput("fp_drained_pend", 32'(pend_f), 32'h0);

        $display("[TB] overflow, clear and same-edge re-strobe");
        req_f = 4'b1000; pin_f[3] = 8'h11;
        applyStimulus(1);
        req_f = 4'b1000; pin_f[3] = 8'h22;
        applyStimulus(1);
        req_f = '0; pin_f = '0;
        checkOutput("ovf_irq", 32'(irq_f), 32'h8);
        checkOutput("ovf_lanes", pout_f, 32'h11000000);
        checkOutput("ovf_flag", 32'(ovf_f), 32'h8);
        clr_f = 1'b1;
        applyStimulus(1);
        clr_f = 1'b0;
        checkOutput("ovf_cleared", 32'(ovf_f), 32'h0);
        checkOutput("ovf_lanes_frozen", pout_f, 32'h11000000);
        ack_f = 1'b1; req_f = 4'b1000; pin_f[3] = 8'h33;
        applyStimulus(1);
        ack_f = 1'b0; req_f = '0; pin_f = '0;
        checkOutput("restrobe_valid", 32'(valid_f), 32'h0);
        checkOutput("restrobe_ovf", 32'(ovf_f), 32'h0);
        checkOutput("restrobe_pend", 32'(pend_f), 32'h8);
        applyStimulus(1);
        checkOutput("restrobe_irq", 32'(irq_f), 32'h8);
        checkOutput("restrobe_lanes", pout_f, 32'h33000000);
        ack_f = 1'b1;
        applyStimulus(1);
        ack_f = 1'b0;

        $display("[TB] asynchronous reset while presenting");
        req_f = 4'b1100; pin_f[3] = 8'h44; pin_f[2] = 8'h55;
        applyStimulus(1);
        req_f = '0; pin_f = '0;
        applyStimulus(1);
        checkOutput("prerst_irq", 32'(irq_f), 32'h8);
        checkOutput("prerst_pend", 32'(pend_f), 32'hC);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(valid_f), 32'h0);
        checkOutput("arst_irq", 32'(irq_f), 32'h0);
        checkOutput("arst_lanes", pout_f, 32'h0);
        checkOutput("arst_pend", 32'(pend_f), 32'h0);
        applyStimulus(1);
        rst_n = 1'b1;
        applyStimulus(3);
        checkOutput("postrst_valid", 32'(valid_f), 32'h0);
        checkOutput("postrst_pend", 32'(pend_f), 32'h0);

        $display("[TB] round-robin between sources a and d");
        pin_r[3] = 8'h3C; pin_r[0] = 8'h0C;
        req_r = 4'b1001;
        applyStimulus(1);
        req_r = '0;
        applyStimulus(1);
        for (int i = 0; i < 6; i++) begin
            exp_irq  = (i % 2 == 0) ? 4'b1000 : 4'b0001;
            exp_lane = (i % 2 == 0) ? 32'h3C000000 : 32'h0000000C;
            checkOutput("rr_irq", 32'(irq_r), 32'(exp_irq));
            checkOutput("rr_lanes", pout_r, exp_lane);
            ack_r = 1'b1; req_r = exp_irq;
            applyStimulus(1);
            ack_r = 1'b0; req_r = '0;
            checkOutput("rr_gap_valid", 32'(valid_r), 32'h0);
            applyStimulus(1);
        end
        checkOutput("rr_ovf", 32'(ovf_r), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_capture_arbiter.md
# irq_capture_arbiter

- Captures one-cycle interrupt strobes from four sources, each with an 8-bit payload, and holds them as pending events.
- Presents exactly one pending event at a time to the downstream interrupt router:
  - a strictly one-hot `interrupt_o` vector;
  - the matching payload lane.
- Holds the presented event stable under a valid/ack handshake.
- Sits directly upstream of the router, so the router's unique-case decode is never fed an overlapping vector.

## Interface

Parameters:
- `RR_EN`, default 0: 0 = fixed priority (source 3 highest, then 2, 1, 0); 1 = round-robin.
- `W`, default 8: payload width per source.

Ports:
- `clk_i`  in  1  clock. One clock; reset is asynchronous and active-low.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  4  one-cycle event strobes; bit 3 = source a, bit 2 = b, bit 1 = c, bit 0 = d.
- `a_i`, `b_i`, `c_i`, `d_i`  in  W each  payloads, sampled in the cycle their strobe is high.
- `ack_i`  in  1  downstream has consumed the presented event.
- `ovf_clr_i`  in  1  clears all overflow flags.
- `valid_o`  out  1  an event is being presented.
- `interrupt_o`  out  4  one-hot when `valid_o`=1, else 0.
- `a_o`, `b_o`, `c_o`, `d_o`  out  W each  granted lane carries the latched payload; the other lanes are 0.
- `pending_o`  out  4  current pending flags.
- `ovf_o`  out  4  sticky per-source overflow flags.

## Operation

Capture, per source k, at each clock edge:
- `req_i[k]`=1 and `pending[k]`=0: set `pending[k]` and latch the payload.
- `req_i[k]`=1, `pending[k]`=1, and k is not being acked this edge: set `ovf[k]`. The payload is NOT overwritten and the event is dropped.
- `req_i[k]`=1 in the same edge that acks k: `pending[k]` stays 1, the new payload is latched, and no overflow is raised.
- `ovf_clr_i` clears all overflow flags. A simultaneous new overflow on the same edge wins, so that flag stays 1.

FSM has two states, IDLE and PRESENT:
- IDLE: if `pending` != 0, select the winner and register:
  - `interrupt_o` = one-hot(winner);
  - winner's payload on its lane, other lanes 0;
  - `valid_o` = 1.
  Then go to PRESENT. Otherwise stay in IDLE with all outputs 0.
- PRESENT: outputs are frozen. New strobes only update the pending and overflow registers.
  - `ack_i`=1: clear `pending[winner]`; `valid_o`, `interrupt_o` and all lanes go to 0; return to IDLE.
  - `ack_i`=0: stay in PRESENT indefinitely.
- `ack_i` in IDLE is ignored.

Winner selection:
- Fixed priority: highest set bit of `pending`.
- Round-robin:
  - Search starts at the bit below the last winner and descends, wrapping from 0 to 3.
  - The pointer resets to 3, so the first search starts at bit 3.
  - The pointer updates only when a grant is made.

Reset (asserted at any time, including mid-handshake) immediately forces all of the following to 0:
- `pending`, `ovf`, all latched payloads;
- `valid_o`, `interrupt_o`, all `*_o` lanes;
- FSM to IDLE, RR pointer to 3.

## Timing

- Strobe sampled at edge E0 → `pending` set after E0 → `valid_o` high after E1. Latency is 2 cycles.
- Ack sampled at edge E → outputs 0 after E. The earliest next grant appears after E+1.
- Minimum spacing between grants is 2 cycles. Between grants there is one cycle in which `valid_o`=0.
- All outputs are registered. There is no combinational path from any input to any output.
- `interrupt_o` is never multi-hot, and it changes only on a grant edge or an ack edge.

## Test plan

- Reset, then `req_i`=4'b0010 with `c_i`=8'h5A in one cycle → 2 cycles later `valid_o`=1, `interrupt_o`=4'b0010, `c_o`=8'h5A, other lanes 0. Hold `ack_i`=0 for 10 cycles → outputs unchanged. Ack → all outputs 0 on the next cycle.
- Fixed priority: `req_i`=4'b1111 in one cycle with payloads 8'hA0, 8'hB0, 8'hC0, 8'hD0; ack each grant immediately → grant order 1000, 0100, 0010, 0001 with the matching payloads, one idle cycle between grants.
- Round-robin (`RR_EN`=1): keep sources 3 and 0 re-strobed on every ack edge → grants alternate 1000, 0001, 1000, 0001; neither source starves.
- Overflow: strobe a with 8'h11, then strobe a again with 8'h22 before the ack → `ovf_o[3]`=1 and the presented `a_o`=8'h11. Pulse `ovf_clr_i` → `ovf_o` returns to 0.
- Strobe a with 8'h33 on the same edge that acks a's current event → no overflow, and the next grant is a with 8'h33.
- Assert `rst_ni`=0 while in PRESENT with two sources pending → all outputs 0 immediately (asynchronously). After release, no grant appears until a new strobe.
